// File: rtl/sprite_compositor.sv
// Two-stage pixel compositor: prioritised square sprites over a selectable background,
// with matched sync delay, per-frame sprite collision flags and a frame counter.
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_SIZE = 32,
    parameter int COL_W       = 12,
    parameter int ROW_W       = 11,
    parameter int TILE_LOG2   = 7
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [COL_W-1:0]           display_col,
    input  logic [ROW_W-1:0]           display_row,
    input  logic                       visible,
    input  logic                       hsync,
    input  logic                       vsync,
    input  logic [NUM_SPRITES*COL_W-1:0] sprite_x,
    input  logic [NUM_SPRITES*ROW_W-1:0] sprite_y,
    input  logic [NUM_SPRITES-1:0]     sprite_en,
    input  logic [NUM_SPRITES*15-1:0]  sprite_color,
    input  logic [8:0]                 bg_tint,
    input  logic [1:0]                 bg_mode,
    output logic [7:0]                 VGA_R,
    output logic [7:0]                 VGA_G,
    output logic [7:0]                 VGA_B,
    output logic                       VGA_HS,
    output logic                       VGA_VS,
    output logic                       VGA_BLANK_N,
    output logic [NUM_SPRITES-1:0]     collision,
    output logic                       frame_done,
    output logic [15:0]                frame_count
);

    localparam int unsigned SPAN = SPRITE_SIZE - 1;
    localparam logic [COL_W:0] COL_SPAN = SPAN[COL_W:0];
    localparam logic [ROW_W:0] ROW_SPAN = SPAN[ROW_W:0];

    logic [COL_W:0]              col_ext;
    logic [ROW_W:0]              row_ext;
    logic                        tile_bit;
    logic [4:0]                  bg_low;

    logic [NUM_SPRITES-1:0]      hit_p1_d, hit_p1_q;
    logic [NUM_SPRITES*15-1:0]   color_p1_d, color_p1_q;
    logic [7:0]                  bg_r_p1_d, bg_r_p1_q;
    logic [7:0]                  bg_g_p1_d, bg_g_p1_q;
    logic [7:0]                  bg_b_p1_d, bg_b_p1_q;
    logic                        vis_p1_d, vis_p1_q;
    logic                        hs_p1_d, hs_p1_q;
    logic                        vs_p1_d, vs_p1_q;

    logic                        sel_hit;
    logic [14:0]                 sel_color;
    logic [7:0]                  r_p2_d, r_p2_q;
    logic [7:0]                  g_p2_d, g_p2_q;
    logic [7:0]                  b_p2_d, b_p2_q;
    logic                        vis_p2_d, vis_p2_q;
    logic                        hs_p2_d, hs_p2_q;
    logic                        vs_p2_d, vs_p2_q;

    logic                        multi_hit;
    logic                        frame_edge;
    logic [NUM_SPRITES-1:0]      acc_d, acc_q;
    logic [NUM_SPRITES-1:0]      collision_d, collision_q;
    logic                        frame_done_d, frame_done_q;
    logic [15:0]                 frame_count_d, frame_count_q;

    // Stage 1: sprite hit tests (one extra bit so right/bottom edges clip) and background colour
    always_comb begin
        col_ext  = {1'b0, display_col};
        row_ext  = {1'b0, display_row};
        hit_p1_d = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit_p1_d[i] = sprite_en[i] & visible
                & (col_ext >= {1'b0, sprite_x[i*COL_W +: COL_W]})
                & (col_ext <= ({1'b0, sprite_x[i*COL_W +: COL_W]} + COL_SPAN))
                & (row_ext >= {1'b0, sprite_y[i*ROW_W +: ROW_W]})
                & (row_ext <= ({1'b0, sprite_y[i*ROW_W +: ROW_W]} + ROW_SPAN));
        end

        tile_bit = display_row[TILE_LOG2] ^ display_col[TILE_LOG2];
        case (bg_mode)
            2'd0:    bg_low = {5{tile_bit}};
            2'd2:    bg_low = display_col[COL_W-1 -: 5];
            default: bg_low = 5'd0;
        endcase

        if (bg_mode == 2'd3) begin
            bg_r_p1_d = 8'd0;
            bg_g_p1_d = 8'd0;
            bg_b_p1_d = 8'd0;
        end else begin
            bg_r_p1_d = {bg_tint[8:6], bg_low};
            bg_g_p1_d = {bg_tint[5:3], bg_low};
            bg_b_p1_d = {bg_tint[2:0], bg_low};
        end

        color_p1_d = sprite_color;
        vis_p1_d   = visible;
        hs_p1_d    = hsync;
        vs_p1_d    = vsync;
    end

    // Stage 2: priority select, lowest index wins because it is applied last
    always_comb begin
        sel_hit   = 1'b0;
        sel_color = 15'd0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_p1_q[i]) begin
                sel_hit   = 1'b1;
                sel_color = color_p1_q[i*15 +: 15];
            end
        end

        if (!vis_p1_q) begin
            r_p2_d = 8'd0;
            g_p2_d = 8'd0;
            b_p2_d = 8'd0;
        end else if (sel_hit) begin
            r_p2_d = {sel_color[14:10], 3'b000};
            g_p2_d = {sel_color[9:5],   3'b000};
            b_p2_d = {sel_color[4:0],   3'b000};
        end else begin
            r_p2_d = bg_r_p1_q;
            g_p2_d = bg_g_p1_q;
            b_p2_d = bg_b_p1_q;
        end

        vis_p2_d = vis_p1_q;
        hs_p2_d  = hs_p1_q;
        vs_p2_d  = vs_p1_q;
    end

    // Collision accumulation as pixels enter stage 2; frame boundary is the delayed vsync fall
    always_comb begin
        multi_hit     = (hit_p1_q & (hit_p1_q - NUM_SPRITES'(1))) != '0;
        frame_edge    = vs_p2_q & ~vs_p1_q;
        acc_d         = acc_q;
        collision_d   = collision_q;
        frame_done_d  = frame_edge;
        frame_count_d = frame_count_q;

        if (vis_p1_q && multi_hit) begin
            acc_d = acc_q | hit_p1_q;
        end
        if (frame_edge) begin
            collision_d   = acc_q;
            acc_d         = '0;
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_p1_q      <= '0;
            color_p1_q    <= '0;
            bg_r_p1_q     <= 8'd0;
            bg_g_p1_q     <= 8'd0;
            bg_b_p1_q     <= 8'd0;
            vis_p1_q      <= 1'b0;
            hs_p1_q       <= 1'b1;
            vs_p1_q       <= 1'b1;
            r_p2_q        <= 8'd0;
            g_p2_q        <= 8'd0;
            b_p2_q        <= 8'd0;
            vis_p2_q      <= 1'b0;
            hs_p2_q       <= 1'b1;
            vs_p2_q       <= 1'b1;
            acc_q         <= '0;
            collision_q   <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            hit_p1_q      <= hit_p1_d;
            color_p1_q    <= color_p1_d;
            bg_r_p1_q     <= bg_r_p1_d;
            bg_g_p1_q     <= bg_g_p1_d;
            bg_b_p1_q     <= bg_b_p1_d;
            vis_p1_q      <= vis_p1_d;
            hs_p1_q       <= hs_p1_d;
            vs_p1_q       <= vs_p1_d;
            r_p2_q        <= r_p2_d;
            g_p2_q        <= g_p2_d;
            b_p2_q        <= b_p2_d;
            vis_p2_q      <= vis_p2_d;
            hs_p2_q       <= hs_p2_d;
            vs_p2_q       <= vs_p2_d;
            acc_q         <= acc_d;
            collision_q   <= collision_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign VGA_R       = r_p2_q;
    assign VGA_G       = g_p2_q;
    assign VGA_B       = b_p2_q;
    assign VGA_HS      = hs_p2_q;
    assign VGA_VS      = vs_p2_q;
    assign VGA_BLANK_N = vis_p2_q;
    assign collision   = collision_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule
